// File: rtl/di_arb_pkg.sv
// di_arb_pkg
//   Shared definitions for the device-interface master arbiter:
//   - arbiter FSM state encoding
//   - default data/address width
//   - master index constants (host path and on-chip sequencer)

package di_arb_pkg;

   localparam int unsigned DW_DEFAULT = 16;

   // Master indices; also used as the value of the last_grant flop.
   localparam logic M_HOST = 1'b0;
   localparam logic M_SEQ  = 1'b1;

   typedef enum logic [2:0] {
      StIdle,
      StSetup,
      StXfer,
      StDrain,
      StDone
   } arb_state_e;

endpackage

// File: rtl/di_arb_rr.sv
// di_arb_rr
//   Two-way round-robin picker. When both masters request, the one that
//   did not win last time is chosen; a single requester always wins.
//
// Ports:
//   req[1:0]    request vector, bit N = master N
//   last_grant  index of the master granted most recently
//   advance     arbiter is able to accept a new grant this cycle
//   gnt_idx     index of the chosen master (meaningful when valid=1)
//   valid       a grant should be issued this cycle

module di_arb_rr
   import di_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   input  logic       advance,
   output logic       gnt_idx,
   output logic       valid
);

   always_comb begin
      valid   = advance & (|req);
      gnt_idx = M_HOST;
      if (req == 2'b11) begin
         gnt_idx = ~last_grant;
      end else if (req[1]) begin
         gnt_idx = M_SEQ;
      end
   end

endmodule

// File: rtl/di_master_arbiter.sv
// di_master_arbiter
//   Shares the single device-interface register bus between the host path
//   (master 0) and the on-chip sequencer (master 1). A master owns the bus
//   for a whole block transaction of len words; per-word strobes are
//   forwarded one per cycle when downstream is ready, read data is returned
//   with a one-cycle rvalid, and each transaction ends with a done pulse
//   (err=1 when aborted by a dropped request or a stalled endpoint).
//
// Ports:
//   if_clock, resetb            clock, asynchronous active-low reset
//   mN_req                      transaction request, held for the whole block
//   mN_rnw/ep_addr/reg_addr/len transaction descriptor, sampled at grant
//   mN_write/mN_wdata           per-word write strobe and data
//   mN_read                     per-word read strobe
//   mN_gnt                      bus granted to master N
//   mN_rdata/mN_rvalid          returned read word and its qualifier
//   mN_done/mN_err              end-of-transaction pulse and abort flag
//   di_*                        downstream register bus

module di_master_arbiter
   import di_arb_pkg::*;
#(
   parameter int unsigned DW             = DW_DEFAULT,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic          if_clock,
   input  logic          resetb,

   input  logic          m0_req,
   input  logic          m0_rnw,
   input  logic [DW-1:0] m0_ep_addr,
   input  logic [DW-1:0] m0_reg_addr,
   input  logic [DW-1:0] m0_len,
   input  logic          m0_write,
   input  logic [DW-1:0] m0_wdata,
   input  logic          m0_read,
   output logic          m0_gnt,
   output logic [DW-1:0] m0_rdata,
   output logic          m0_rvalid,
   output logic          m0_done,
   output logic          m0_err,

   input  logic          m1_req,
   input  logic          m1_rnw,
   input  logic [DW-1:0] m1_ep_addr,
   input  logic [DW-1:0] m1_reg_addr,
   input  logic [DW-1:0] m1_len,
   input  logic          m1_write,
   input  logic [DW-1:0] m1_wdata,
   input  logic          m1_read,
   output logic          m1_gnt,
   output logic [DW-1:0] m1_rdata,
   output logic          m1_rvalid,
   output logic          m1_done,
   output logic          m1_err,

   output logic [DW-1:0] di_ep_addr,
   output logic [DW-1:0] di_reg_addr,
   output logic [DW-1:0] di_reg_data_in,
   output logic          di_write,
   output logic          di_read,
   input  logic [DW-1:0] di_reg_data_out,
   input  logic          di_wr_ready,
   input  logic          di_rd_ready
);

   // Timeout counter width; a disabled timeout still keeps a 1-bit counter.
   localparam int unsigned TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES);

   arb_state_e    state_q;
   logic          idx_q;
   logic          last_grant_q;
   logic          rnw_q;
   logic          abort_q;
   logic [1:0]    req_q;
   logic [1:0]    gnt_q;
   logic [1:0]    done_q;
   logic [1:0]    err_q;
   logic [1:0]    rvalid_q;
   logic [DW-1:0] rdata_q [2];
   logic [DW-1:0] ep_q;
   logic [DW-1:0] reg_q;
   logic [DW-1:0] remaining_q;
   logic [DW-1:0] wdata_q;
   logic          di_write_q;
   logic          di_read_q;
   logic [TW-1:0] tmo_q;

   logic [1:0]    req;
   logic [1:0]    eligible;
   logic          rr_idx;
   logic          rr_valid;
   logic          sel_req;
   logic          sel_write;
   logic          sel_read;
   logic [DW-1:0] sel_wdata;
   logic          strobe_ok;
   logic [TW-1:0] tmo_inc;
   logic          tmo_hit;
   logic          xfer_abort;

   assign req = {m1_req, m0_req};

   // Requiring req on two consecutive edges gives the two-cycle grant
   // latency and keeps a master that drops req right after done from
   // being re-granted off a stale sample.
   assign eligible = req & req_q;

   di_arb_rr u_rr (
      .req        (eligible),
      .last_grant (last_grant_q),
      .advance    (state_q == StIdle),
      .gnt_idx    (rr_idx),
      .valid      (rr_valid)
   );

   // Only the granted master's controls are ever looked at.
   assign sel_req   = (idx_q == M_SEQ) ? m1_req   : m0_req;
   assign sel_write = (idx_q == M_SEQ) ? m1_write : m0_write;
   assign sel_read  = (idx_q == M_SEQ) ? m1_read  : m0_read;
   assign sel_wdata = (idx_q == M_SEQ) ? m1_wdata : m0_wdata;

   always_comb begin
      strobe_ok = 1'b0;
      if ((state_q == StXfer) && sel_req && (remaining_q != '0)) begin
         strobe_ok = rnw_q ? (sel_read && di_rd_ready) : (sel_write && di_wr_ready);
      end
   end

   // Saturating increment; the abort fires on the cycle the count reaches the limit.
   assign tmo_inc    = (tmo_q == '1) ? tmo_q : tmo_q + TW'(1);
   assign tmo_hit    = (TIMEOUT_CYCLES != 0) && (tmo_inc == TMO_LIMIT);
   assign xfer_abort = !sel_req || ((remaining_q != '0) && !strobe_ok && tmo_hit);

   always_ff @(posedge if_clock or negedge resetb) begin
      if (!resetb) begin
         state_q      <= StIdle;
         idx_q        <= M_HOST;
         last_grant_q <= M_SEQ;
         rnw_q        <= 1'b0;
         abort_q      <= 1'b0;
         req_q        <= '0;
         gnt_q        <= '0;
         done_q       <= '0;
         err_q        <= '0;
         rvalid_q     <= '0;
         rdata_q[0]   <= '0;
         rdata_q[1]   <= '0;
         ep_q         <= '0;
         reg_q        <= '0;
         remaining_q  <= '0;
         wdata_q      <= '0;
         di_write_q   <= 1'b0;
         di_read_q    <= 1'b0;
         tmo_q        <= '0;
      end else begin
         req_q      <= req;
         di_write_q <= 1'b0;
         di_read_q  <= 1'b0;
         rvalid_q   <= '0;
         done_q     <= '0;
         err_q      <= '0;

         // Read data is returned the cycle after each downstream read strobe.
         if (di_read_q) begin
            rdata_q[idx_q]  <= di_reg_data_out;
            rvalid_q[idx_q] <= 1'b1;
         end

         case (state_q)
            StIdle: begin
               if (rr_valid) begin
                  idx_q        <= rr_idx;
                  last_grant_q <= rr_idx;
                  rnw_q        <= (rr_idx == M_SEQ) ? m1_rnw      : m0_rnw;
                  ep_q         <= (rr_idx == M_SEQ) ? m1_ep_addr  : m0_ep_addr;
                  reg_q        <= (rr_idx == M_SEQ) ? m1_reg_addr : m0_reg_addr;
                  remaining_q  <= (rr_idx == M_SEQ) ? m1_len      : m0_len;
                  gnt_q        <= (rr_idx == M_SEQ) ? 2'b10 : 2'b01;
                  abort_q      <= 1'b0;
                  tmo_q        <= '0;
                  state_q      <= StSetup;
               end
            end

            StSetup: begin
               if (!sel_req) begin
                  done_q[idx_q] <= 1'b1;
                  err_q[idx_q]  <= 1'b1;
                  state_q       <= StDone;
               end else if (remaining_q == '0) begin
                  done_q[idx_q] <= 1'b1;
                  state_q       <= StDone;
               end else begin
                  state_q <= StXfer;
               end
            end

            StXfer: begin
               if (xfer_abort) begin
                  // A read issued last cycle still owes its rvalid.
                  abort_q <= 1'b1;
                  if (di_read_q) begin
                     state_q <= StDrain;
                  end else begin
                     done_q[idx_q] <= 1'b1;
                     err_q[idx_q]  <= 1'b1;
                     state_q       <= StDone;
                  end
               end else if (remaining_q == '0) begin
                  if (rnw_q) begin
                     state_q <= StDrain;
                  end else begin
                     done_q[idx_q] <= 1'b1;
                     state_q       <= StDone;
                  end
               end else if (strobe_ok) begin
                  di_write_q  <= !rnw_q;
                  di_read_q   <= rnw_q;
                  if (!rnw_q) begin
                     wdata_q <= sel_wdata;
                  end
                  remaining_q <= remaining_q - DW'(1);
                  tmo_q       <= '0;
               end else begin
                  tmo_q <= tmo_inc;
               end
            end

            StDrain: begin
               done_q[idx_q] <= 1'b1;
               err_q[idx_q]  <= abort_q;
               state_q       <= StDone;
            end

            StDone: begin
               gnt_q   <= '0;
               state_q <= StIdle;
            end

            default: begin
               gnt_q   <= '0;
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign m0_gnt    = gnt_q[0];
   assign m1_gnt    = gnt_q[1];
   assign m0_rdata  = rdata_q[0];
   assign m1_rdata  = rdata_q[1];
   assign m0_rvalid = rvalid_q[0];
   assign m1_rvalid = rvalid_q[1];
   assign m0_done   = done_q[0];
   assign m1_done   = done_q[1];
   assign m0_err    = err_q[0];
   assign m1_err    = err_q[1];

   assign di_ep_addr     = ep_q;
   assign di_reg_addr    = reg_q;
   assign di_reg_data_in = wdata_q;
   assign di_write       = di_write_q;
   assign di_read        = di_read_q;

endmodule

// File: tb/tb_di_master_arbiter.sv
// tb_di_master_arbiter
//   Directed bench for di_master_arbiter. Inputs change 1 ns after each
//   rising edge and outputs are checked at that same point, so every check
//   reflects the state left by the edge just passed.

module tb_di_master_arbiter;

   localparam int unsigned DW = 16;

   logic          if_clock = 1'b0;
   logic          resetb;

   logic          m0_req, m0_rnw, m0_write, m0_read;
   logic [DW-1:0] m0_ep_addr, m0_reg_addr, m0_len, m0_wdata;
   logic          m0_gnt, m0_rvalid, m0_done, m0_err;
   logic [DW-1:0] m0_rdata;

   logic          m1_req, m1_rnw, m1_write, m1_read;
   logic [DW-1:0] m1_ep_addr, m1_reg_addr, m1_len, m1_wdata;
   logic          m1_gnt, m1_rvalid, m1_done, m1_err;
   logic [DW-1:0] m1_rdata;

   logic [DW-1:0] di_ep_addr, di_reg_addr, di_reg_data_in, di_reg_data_out;
   logic          di_write, di_read, di_wr_ready, di_rd_ready;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 if_clock = ~if_clock;

   di_master_arbiter #(
      .DW             (DW),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .if_clock        (if_clock),
      .resetb          (resetb),
      .m0_req          (m0_req),
      .m0_rnw          (m0_rnw),
      .m0_ep_addr      (m0_ep_addr),
      .m0_reg_addr     (m0_reg_addr),
      .m0_len          (m0_len),
      .m0_write        (m0_write),
      .m0_wdata        (m0_wdata),
      .m0_read         (m0_read),
      .m0_gnt          (m0_gnt),
      .m0_rdata        (m0_rdata),
      .m0_rvalid       (m0_rvalid),
      .m0_done         (m0_done),
      .m0_err          (m0_err),
      .m1_req          (m1_req),
      .m1_rnw          (m1_rnw),
      .m1_ep_addr      (m1_ep_addr),
      .m1_reg_addr     (m1_reg_addr),
      .m1_len          (m1_len),
      .m1_write        (m1_write),
      .m1_wdata        (m1_wdata),
      .m1_read         (m1_read),
      .m1_gnt          (m1_gnt),
      .m1_rdata        (m1_rdata),
      .m1_rvalid       (m1_rvalid),
      .m1_done         (m1_done),
      .m1_err          (m1_err),
      .di_ep_addr      (di_ep_addr),
      .di_reg_addr     (di_reg_addr),
      .di_reg_data_in  (di_reg_data_in),
      .di_write        (di_write),
      .di_read         (di_read),
      .di_reg_data_out (di_reg_data_out),
      .di_wr_ready     (di_wr_ready),
      .di_rd_ready     (di_rd_ready)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge if_clock);
      #1;
   endtask

   task automatic clear_masters();
      m0_req = 1'b0; m0_rnw = 1'b0; m0_write = 1'b0; m0_read = 1'b0;
      m0_ep_addr = '0; m0_reg_addr = '0; m0_len = '0; m0_wdata = '0;
      m1_req = 1'b0; m1_rnw = 1'b0; m1_write = 1'b0; m1_read = 1'b0;
      m1_ep_addr = '0; m1_reg_addr = '0; m1_len = '0; m1_wdata = '0;
   endtask

   task automatic start_m0(input logic rnw, input logic [DW-1:0] ep, input logic [DW-1:0] reg_a,
                           input logic [DW-1:0] len);
      m0_rnw = rnw; m0_ep_addr = ep; m0_reg_addr = reg_a; m0_len = len; m0_req = 1'b1;
   endtask

   task automatic start_m1(input logic rnw, input logic [DW-1:0] ep, input logic [DW-1:0] reg_a,
                           input logic [DW-1:0] len);
      m1_rnw = rnw; m1_ep_addr = ep; m1_reg_addr = reg_a; m1_len = len; m1_req = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      resetb = 1'b1;
      clear_masters();
      di_reg_data_out = '0;
      di_wr_ready     = 1'b1;
      di_rd_ready     = 1'b1;
      #1 resetb = 1'b0;
      #2;
      check("reset_outs", {m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err,
                           m0_rvalid, m1_rvalid, di_write, di_read}, '0);
      check("reset_addr", {di_ep_addr, di_reg_addr}, '0);
      check("reset_data", {m0_rdata, di_reg_data_in}, '0);
      #20 resetb = 1'b1;
      step();

      // Single write block, master 0, three words.
      start_m0(1'b0, 16'h0002, 16'h0010, 16'd3);
      step(); check("wr_gnt_early", m0_gnt, 1'b0);
      step(); check("wr_gnt", {m0_gnt, m1_gnt}, 2'b10);
      check("wr_addr", {di_ep_addr, di_reg_addr}, 32'h0002_0010);
      m0_write = 1'b1; m0_wdata = 16'h00A1;
      step(); check("wr_setup_quiet", di_write, 1'b0);
      step(); check("wr_w1", {di_write, di_reg_data_in}, {1'b1, 16'h00A1});
      m0_wdata = 16'h00A2;
      step(); check("wr_w2", {di_write, di_reg_data_in}, {1'b1, 16'h00A2});
      m0_wdata = 16'h00A3;
      step(); check("wr_w3", {di_write, di_reg_data_in}, {1'b1, 16'h00A3});
      m0_write = 1'b0;
      step(); check("wr_done", {di_write, m0_done, m0_err, m0_gnt}, 4'b0101);
      step(); check("wr_release", {m0_gnt, m0_done}, 2'b00);
      clear_masters();
      step();

      // Single read block, master 1, two words.
      start_m1(1'b1, 16'h0003, 16'h0020, 16'd2);
      m1_read = 1'b1; di_reg_data_out = 16'h1234;
      step(); step(); check("rd_gnt", {m0_gnt, m1_gnt}, 2'b01);
      check("rd_addr", {di_ep_addr, di_reg_addr}, 32'h0003_0020);
      step();
      step(); check("rd_r1", {di_read, m1_rvalid, di_write}, 3'b100);
      step(); check("rd_v1", {di_read, m1_rvalid, m1_rdata}, {2'b11, 16'h1234});
      check("rd_m0_quiet", m0_rvalid, 1'b0);
      di_reg_data_out = 16'h5678;
      step(); check("rd_v2", {di_read, m1_rvalid, m1_rdata, m1_done}, {2'b01, 16'h5678, 1'b0});
      step(); check("rd_done", {m1_done, m1_err, m1_rvalid}, 3'b100);
      clear_masters();
      step(); step();

      // Contention straight after reset: host first, then sequencer.
      resetb = 1'b0; #2 resetb = 1'b1;
      step();
      start_m0(1'b0, 16'h0004, 16'h0040, 16'd1); m0_write = 1'b1; m0_wdata = 16'h00A5;
      start_m1(1'b0, 16'h0005, 16'h0050, 16'd1); m1_write = 1'b1; m1_wdata = 16'h00B1;
      step(); step(); check("ct_first", {m0_gnt, m1_gnt}, 2'b10);
      step(); step(); check("ct_w0", {di_write, di_reg_data_in}, {1'b1, 16'h00A5});
      step(); check("ct_done0", {m0_done, m1_done, m1_gnt}, 3'b100);
      m0_req = 1'b0; m0_write = 1'b0;
      step(); check("ct_idle_gap", {m0_gnt, m1_gnt}, 2'b00);
      step(); check("ct_second", {m0_gnt, m1_gnt}, 2'b01);
      check("ct_addr1", {di_ep_addr, di_reg_addr}, 32'h0005_0050);
      step(); step(); check("ct_w1", {di_write, di_reg_data_in}, {1'b1, 16'h00B1});
      step(); check("ct_done1", {m1_done, m1_err}, 2'b10);
      m1_req = 1'b0; m1_write = 1'b0;
      step();
      m0_req = 1'b1; m1_req = 1'b1;
      step(); step(); check("ct_rr_again", {m0_gnt, m1_gnt}, 2'b10);
      m0_req = 1'b0; m1_req = 1'b0;
      step(); check("setup_abort", {m0_done, m0_err}, 2'b11);
      step(); step(); check("ct_no_stale", {m0_gnt, m1_gnt}, 2'b00);
      clear_masters();

      // Zero-length block.
      start_m0(1'b0, 16'h0006, 16'h0060, 16'd0); m0_write = 1'b1;
      step(); step(); check("z_gnt", m0_gnt, 1'b1);
      step(); check("z_done", {m0_done, m0_err, di_write, di_read}, 4'b1000);
      clear_masters();
      step(); check("z_release", m0_gnt, 1'b0);

      // Stalled endpoint: timeout after 8 XFER cycles.
      di_wr_ready = 1'b0;
      start_m0(1'b0, 16'h0007, 16'h0070, 16'd2); m0_write = 1'b1; m0_wdata = 16'h00C1;
      step(); step(); step();
      for (int i = 0; i < 7; i++) begin
         step(); check("stall_wait", {m0_done, di_write, m0_gnt}, 3'b001);
      end
      step(); check("stall_timeout", {m0_done, m0_err, di_write}, 3'b110);
      clear_masters(); di_wr_ready = 1'b1;
      step();

      // Read block aborted after the first word.
      start_m0(1'b1, 16'h0008, 16'h0080, 16'd4); m0_read = 1'b1; di_reg_data_out = 16'h0BAD;
      step(); step(); step();
      step(); check("ab_r1", {di_read, m0_rvalid}, 2'b10);
      m0_req = 1'b0;
      step(); check("ab_drain", {di_read, m0_rvalid, m0_rdata, m0_done}, {2'b01, 16'h0BAD, 1'b0});
      step(); check("ab_done", {m0_done, m0_err, m0_rvalid, di_read}, 4'b1100);
      clear_masters();
      step(); check("ab_release", m0_gnt, 1'b0);

      // Reset in the middle of a write block.
      start_m0(1'b0, 16'h0009, 16'h0090, 16'd4); m0_write = 1'b1; m0_wdata = 16'h00C3;
      step(); step(); step();
      step(); check("rst_pre", {di_write, di_reg_data_in}, {1'b1, 16'h00C3});
      #3 resetb = 1'b0;
      #1;
      check("rst_async", {m0_gnt, di_write, m0_done, m0_err}, 4'b0000);
      check("rst_async_data", {di_ep_addr, di_reg_data_in}, '0);
      step(); check("rst_hold", {di_write, m0_gnt}, 2'b00);
      start_m1(1'b0, 16'h000A, 16'h00A0, 16'd1);
      #3 resetb = 1'b1;
      step(); check("rst_post_idle", {m0_gnt, m1_gnt}, 2'b00);
      step(); check("rst_first_m0", {m0_gnt, m1_gnt}, 2'b10);
      check("rst_first_addr", {di_ep_addr, di_reg_addr}, 32'h0009_0090);
      clear_masters();
      step(); step(); step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
